// File: rtl/udt_tx_scheduler.sv
// Packet-atomic arbiter muxing UDT control and data packet streams onto one UDP tx stream.
// Optional fairness (macro UDT_TX_FAIR_EN): data is granted after CTRL_BURST_MAX straight control grants.
module udt_tx_scheduler #(
    parameter logic [47:0] FPGA_MAC_SRC         = 48'hba0203040506,
    parameter logic [47:0] FPGA_MAC_DES         = 48'hffffffffffff,
    parameter logic [31:0] FPGA_IP_SRC          = 32'hc0a8006f,
    parameter logic [31:0] FPGA_IP_DES_DEAFAULT = 32'hc0a800ff,
    parameter int          PORT                 = 10086,
    parameter int          CTRL_BURST_MAX       = 4,
    // reset value of both packet counters; nonzero only to reach the wrap point quickly
    parameter logic [15:0] PKT_CNT_INIT         = 16'd0
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic [47:0] cfg_mac_dest,
    input  logic [31:0] cfg_ip_dest,
    input  logic [15:0] cfg_port_dest,
    input  logic        ctrl_tvalid,
    output logic        ctrl_tready,
    input  logic [63:0] ctrl_tdata,
    input  logic [7:0]  ctrl_tkeep,
    input  logic        ctrl_tlast,
    input  logic        data_tvalid,
    output logic        data_tready,
    input  logic [63:0] data_tdata,
    input  logic [7:0]  data_tkeep,
    input  logic        data_tlast,
    input  logic        udp_tx_tready,
    output logic        udp_tx_tvalid,
    output logic        udp_tx_tlast,
    output logic [7:0]  udp_tx_tkeep,
    output logic [63:0] udp_tx_tdata,
    output logic [47:0] udp_tx_mac_src,
    output logic [47:0] udp_tx_mac_dest,
    output logic [31:0] udp_tx_ip_src,
    output logic [31:0] udp_tx_ip_dest,
    output logic [15:0] udp_tx_port_src,
    output logic [15:0] udp_tx_port_dest,
    output logic        sched_busy,
    output logic [15:0] ctrl_pkt_cnt,
    output logic [15:0] data_pkt_cnt
);

    typedef enum logic [1:0] {IDLE, CTRL, DATA} state_t;

    state_t state;
    logic   grant_data;

`ifdef UDT_TX_FAIR_EN
    localparam logic [7:0] BURST = 8'(CTRL_BURST_MAX);
    logic [7:0] ctrl_run;

    assign grant_data = data_tvalid && (!ctrl_tvalid || ctrl_run >= BURST);
`else
    logic [7:0] unused_burst;

    assign unused_burst = 8'(CTRL_BURST_MAX);
    assign grant_data   = data_tvalid && !ctrl_tvalid;
`endif

    assign udp_tx_mac_src  = FPGA_MAC_SRC;
    assign udp_tx_ip_src   = FPGA_IP_SRC;
    assign udp_tx_port_src = 16'(PORT);
    assign sched_busy      = (state != IDLE);

    // Pass-through is gated by reset so tready drops in the very cycle reset is sampled.
    always_comb begin
        udp_tx_tvalid = 1'b0;
        udp_tx_tlast  = 1'b0;
        udp_tx_tkeep  = 8'h00;
        udp_tx_tdata  = 64'h0;
        ctrl_tready   = 1'b0;
        data_tready   = 1'b0;
        if (!core_rst) begin
            case (state)
                CTRL: begin
                    udp_tx_tvalid = ctrl_tvalid;
                    udp_tx_tlast  = ctrl_tlast;
                    udp_tx_tkeep  = ctrl_tkeep;
                    udp_tx_tdata  = ctrl_tdata;
                    ctrl_tready   = udp_tx_tready;
                end
                DATA: begin
                    udp_tx_tvalid = data_tvalid;
                    udp_tx_tlast  = data_tlast;
                    udp_tx_tkeep  = data_tkeep;
                    udp_tx_tdata  = data_tdata;
                    data_tready   = udp_tx_tready;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state            <= IDLE;
            ctrl_pkt_cnt     <= PKT_CNT_INIT;
            data_pkt_cnt     <= PKT_CNT_INIT;
            udp_tx_mac_dest  <= FPGA_MAC_DES;
            udp_tx_ip_dest   <= FPGA_IP_DES_DEAFAULT;
            udp_tx_port_dest <= 16'(PORT);
`ifdef UDT_TX_FAIR_EN
            ctrl_run         <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data || ctrl_tvalid) begin
                        udp_tx_mac_dest  <= cfg_mac_dest;
                        udp_tx_ip_dest   <= cfg_ip_dest;
                        udp_tx_port_dest <= cfg_port_dest;
                    end
                    if (grant_data) begin
                        state <= DATA;
`ifdef UDT_TX_FAIR_EN
                        ctrl_run <= 8'd0;
`endif
                    end else if (ctrl_tvalid) begin
                        state <= CTRL;
`ifdef UDT_TX_FAIR_EN
                        if (ctrl_run != 8'hff) ctrl_run <= ctrl_run + 8'd1;
`endif
                    end
                end
                CTRL: begin
                    if (ctrl_tvalid && udp_tx_tready && ctrl_tlast) begin
                        state        <= IDLE;
                        ctrl_pkt_cnt <= ctrl_pkt_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (data_tvalid && udp_tx_tready && data_tlast) begin
                        state        <= IDLE;
                        data_pkt_cnt <= data_pkt_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udt_tx_scheduler.sv
// Directed bench for udt_tx_scheduler: reset, single packet, priority, stall, fairness, reset abort, wrap.
module tb_udt_tx_scheduler;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic [47:0] cfg_mac_dest = 48'h001122334455;
    logic [31:0] cfg_ip_dest = 32'hc0a80010;
    logic [15:0] cfg_port_dest = 16'd5000;
    logic        ctrl_tvalid = 1'b0, ctrl_tlast = 1'b0;
    logic [63:0] ctrl_tdata = 64'h0;
    logic [7:0]  ctrl_tkeep = 8'h0;
    logic        data_tvalid = 1'b0, data_tlast = 1'b0;
    logic [63:0] data_tdata = 64'h0;
    logic [7:0]  data_tkeep = 8'h0;
    logic        udp_tx_tready = 1'b1;
    logic        ctrl_tready, data_tready;
    logic        udp_tx_tvalid, udp_tx_tlast;
    logic [7:0]  udp_tx_tkeep;
    logic [63:0] udp_tx_tdata;
    logic [47:0] udp_tx_mac_src, udp_tx_mac_dest;
    logic [31:0] udp_tx_ip_src, udp_tx_ip_dest;
    logic [15:0] udp_tx_port_src, udp_tx_port_dest;
    logic        sched_busy;
    logic [15:0] ctrl_pkt_cnt, data_pkt_cnt;

    // second instance, counters start at 16'hFFFF to exercise the wrap
    logic        unused_w_ctrl_tready, unused_w_data_tready, unused_w_tvalid, unused_w_tlast, unused_w_busy;
    logic [7:0]  unused_w_tkeep;
    logic [63:0] unused_w_tdata;
    logic [47:0] unused_w_mac_src, unused_w_mac_dest;
    logic [31:0] unused_w_ip_src, unused_w_ip_dest;
    logic [15:0] unused_w_port_src, unused_w_port_dest, unused_w_data_cnt;
    logic [15:0] w_ctrl_pkt_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    logic [63:0] log_dat[$];
    logic [7:0]  log_keep[$];
    logic        log_last[$];
    int          log_cyc[$];

    udt_tx_scheduler dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .cfg_mac_dest(cfg_mac_dest), .cfg_ip_dest(cfg_ip_dest), .cfg_port_dest(cfg_port_dest),
        .ctrl_tvalid(ctrl_tvalid), .ctrl_tready(ctrl_tready), .ctrl_tdata(ctrl_tdata),
        .ctrl_tkeep(ctrl_tkeep), .ctrl_tlast(ctrl_tlast),
        .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tdata(data_tdata),
        .data_tkeep(data_tkeep), .data_tlast(data_tlast),
        .udp_tx_tready(udp_tx_tready), .udp_tx_tvalid(udp_tx_tvalid), .udp_tx_tlast(udp_tx_tlast),
        .udp_tx_tkeep(udp_tx_tkeep), .udp_tx_tdata(udp_tx_tdata),
        .udp_tx_mac_src(udp_tx_mac_src), .udp_tx_mac_dest(udp_tx_mac_dest),
        .udp_tx_ip_src(udp_tx_ip_src), .udp_tx_ip_dest(udp_tx_ip_dest),
        .udp_tx_port_src(udp_tx_port_src), .udp_tx_port_dest(udp_tx_port_dest),
        .sched_busy(sched_busy), .ctrl_pkt_cnt(ctrl_pkt_cnt), .data_pkt_cnt(data_pkt_cnt)
    );

    udt_tx_scheduler #(.PKT_CNT_INIT(16'hffff)) dut_w (
        .core_clk(core_clk), .core_rst(core_rst),
        .cfg_mac_dest(cfg_mac_dest), .cfg_ip_dest(cfg_ip_dest), .cfg_port_dest(cfg_port_dest),
        .ctrl_tvalid(ctrl_tvalid), .ctrl_tready(unused_w_ctrl_tready), .ctrl_tdata(ctrl_tdata),
        .ctrl_tkeep(ctrl_tkeep), .ctrl_tlast(ctrl_tlast),
        .data_tvalid(data_tvalid), .data_tready(unused_w_data_tready), .data_tdata(data_tdata),
        .data_tkeep(data_tkeep), .data_tlast(data_tlast),
        .udp_tx_tready(udp_tx_tready), .udp_tx_tvalid(unused_w_tvalid), .udp_tx_tlast(unused_w_tlast),
        .udp_tx_tkeep(unused_w_tkeep), .udp_tx_tdata(unused_w_tdata),
        .udp_tx_mac_src(unused_w_mac_src), .udp_tx_mac_dest(unused_w_mac_dest),
        .udp_tx_ip_src(unused_w_ip_src), .udp_tx_ip_dest(unused_w_ip_dest),
        .udp_tx_port_src(unused_w_port_src), .udp_tx_port_dest(unused_w_port_dest),
        .sched_busy(unused_w_busy), .ctrl_pkt_cnt(w_ctrl_pkt_cnt), .data_pkt_cnt(unused_w_data_cnt)
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc_n++;

    always @(negedge core_clk) begin
        if (udp_tx_tvalid && udp_tx_tready) begin
            log_dat.push_back(udp_tx_tdata);
            log_keep.push_back(udp_tx_tkeep);
            log_last.push_back(udp_tx_tlast);
            log_cyc.push_back(cyc_n);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge core_clk);
        #1;
    endtask

    task automatic clear_log();
        log_dat.delete();
        log_keep.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    // One packet of n beats; last beat carries tkeep 8'h0f.
    task automatic send_ctrl(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            ctrl_tvalid = 1'b1;
            ctrl_tdata  = base + 64'(i);
            ctrl_tkeep  = (i == n - 1) ? 8'h0f : 8'hff;
            ctrl_tlast  = (i == n - 1);
            @(negedge core_clk);
            while (!ctrl_tready && t < 60) begin
                t++;
                @(negedge core_clk);
            end
            if (!ctrl_tready) check("ctrl_hs_timeout", 64'd0, 64'd1);
            cyc();
        end
        ctrl_tvalid = 1'b0;
        ctrl_tlast  = 1'b0;
    endtask

    task automatic send_data(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            data_tvalid = 1'b1;
            data_tdata  = base + 64'(i);
            data_tkeep  = (i == n - 1) ? 8'h0f : 8'hff;
            data_tlast  = (i == n - 1);
            @(negedge core_clk);
            while (!data_tready && t < 60) begin
                t++;
                @(negedge core_clk);
            end
            if (!data_tready) check("data_hs_timeout", 64'd0, 64'd1);
            cyc();
        end
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int exp_d[10];
        logic [15:0] snap_d;

        // reset then idle (control request held during reset must not leak out)
        ctrl_tvalid = 1'b1;
        cyc();
        #1;
        check("rst_ctrl_tready", 64'(ctrl_tready), 64'd0);
        check("rst_tvalid", 64'(udp_tx_tvalid), 64'd0);
        ctrl_tvalid = 1'b0;
        cyc();
        core_rst = 1'b0;
        #1;
        check("rst_tdata", udp_tx_tdata, 64'd0);
        check("rst_tkeep_tlast", {55'd0, udp_tx_tkeep, udp_tx_tlast}, 64'd0);
        check("rst_ip_dest", 64'(udp_tx_ip_dest), 64'hc0a800ff);
        check("rst_port_dest", 64'(udp_tx_port_dest), 64'd10086);
        check("rst_mac_dest", 64'(udp_tx_mac_dest), 64'hffffffffffff);
        check("rst_src_fields", {udp_tx_ip_src, udp_tx_port_src, 16'd0}, {32'hc0a8006f, 16'd10086, 16'd0});
        check("rst_mac_src", 64'(udp_tx_mac_src), 64'hba0203040506);
        check("rst_counters", {32'd0, ctrl_pkt_cnt, data_pkt_cnt}, 64'd0);
        check("rst_busy", 64'(sched_busy), 64'd0);
        check("rst_wrap_cnt", 64'(w_ctrl_pkt_cnt), 64'hffff);

        // single 3-beat data packet
        cyc();
        clear_log();
        cfg_ip_dest = 32'hc0a80010;
        n0 = cyc_n;
        send_data(3, 64'hd000_0000_0000_0000);
        cyc();
        check("d1_beats", 64'(log_dat.size()), 64'd3);
        check("d1_latency", 64'(log_cyc[0] - n0), 64'd1);
        check("d1_beat0", log_dat[0], 64'hd000_0000_0000_0000);
        check("d1_beat2", log_dat[2], 64'hd000_0000_0000_0002);
        check("d1_keep", {log_keep[0], log_keep[2]}, 64'hff0f);
        check("d1_last", {log_last[0], log_last[1], log_last[2]}, 64'b001);
        check("d1_ip_dest", 64'(udp_tx_ip_dest), 64'hc0a80010);
        check("d1_data_cnt", 64'(data_pkt_cnt), 64'd1);
        check("d1_idle", {sched_busy, udp_tx_tvalid}, 64'd0);

        // simultaneous request: control first, one idle cycle, then data
        clear_log();
        n0 = cyc_n;
        fork
            send_ctrl(2, 64'hc100_0000_0000_0000);
            send_data(2, 64'hd100_0000_0000_0000);
        join
        cyc();
        check("sim_beats", 64'(log_dat.size()), 64'd4);
        check("sim_order", {log_dat[0][63:48], log_dat[1][63:48], log_dat[2][63:48], log_dat[3][63:48]},
              64'hc100_c100_d100_d100);
        check("sim_latency", 64'(log_cyc[0] - n0), 64'd1);
        check("sim_gap", 64'(log_cyc[2] - log_cyc[1]), 64'd2);

        // backpressure on beat 2 of 4, cfg change during the stall
        clear_log();
        fork
            send_data(4, 64'hd200_0000_0000_0000);
            begin
                int t;
                t = 0;
                @(negedge core_clk);
                while (!udp_tx_tvalid && t < 20) begin
                    t++;
                    @(negedge core_clk);
                end
                cyc();
                udp_tx_tready = 1'b0;
                cfg_ip_dest = 32'hc0a80020;
                for (int k = 0; k < 5; k++) begin
                    @(negedge core_clk);
                    check("bp_hold_dat", udp_tx_tdata, 64'hd200_0000_0000_0001);
                    check("bp_hold_vld_rdy", {udp_tx_tvalid, data_tready}, 64'b10);
                end
                check("bp_ip_unchanged", 64'(udp_tx_ip_dest), 64'hc0a80010);
                cyc();
                udp_tx_tready = 1'b1;
            end
        join
        cyc();
        check("bp_beats", 64'(log_dat.size()), 64'd4);
        check("bp_beat1", log_dat[1], 64'hd200_0000_0000_0001);
        check("bp_beat3", log_dat[3], 64'hd200_0000_0000_0003);
        check("bp_last", {log_last[1], log_last[3]}, 64'b01);
        send_ctrl(1, 64'hc250_0000_0000_0000);
        check("bp_next_ip", 64'(udp_tx_ip_dest), 64'hc0a80020);

        // fairness: fresh reset, 8 control packets against 2 pending data packets
        core_rst = 1'b1;
        cyc();
        core_rst = 1'b0;
        clear_log();
        snap_d = 16'hdead;
`ifdef UDT_TX_FAIR_EN
        exp_d = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
        exp_d = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
`endif
        fork
            begin
                for (int p = 0; p < 8; p++) send_ctrl(1, 64'hc300_0000_0000_0000 + 64'(p));
                snap_d = data_pkt_cnt;
            end
            begin
                send_data(1, 64'hd300_0000_0000_0000);
                send_data(1, 64'hd300_0000_0000_0001);
            end
        join
        cyc();
        check("fair_pkts", 64'(log_dat.size()), 64'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("fair_order_%0d", i), 64'(log_dat[i][63:60]), (exp_d[i] != 0) ? 64'hd : 64'hc);
`ifdef UDT_TX_FAIR_EN
        check("fair_data_during_ctrl", 64'(snap_d), 64'd1);
`else
        check("fair_data_during_ctrl", 64'(snap_d), 64'd0);
`endif
        check("fair_counts", {32'd0, ctrl_pkt_cnt, data_pkt_cnt}, {32'd0, 16'd8, 16'd2});

        // reset on beat 2 of a data packet
        data_tvalid = 1'b1;
        data_tdata  = 64'hd400_0000_0000_0000;
        data_tkeep  = 8'hff;
        data_tlast  = 1'b0;
        cyc();
        cyc();
        data_tdata = 64'hd400_0000_0000_0001;
        #1;
        check("mrst_pre_rdy", 64'(data_tready), 64'd1);
        core_rst = 1'b1;
        #1;
        check("mrst_rdy_drop", {data_tready, udp_tx_tvalid}, 64'd0);
        cyc();
        core_rst = 1'b0;
        data_tvalid = 1'b0;
        #1;
        check("mrst_idle", {sched_busy, udp_tx_tvalid}, 64'd0);
        check("mrst_counts", {32'd0, ctrl_pkt_cnt, data_pkt_cnt}, 64'd0);
        check("mrst_wrap_reload", 64'(w_ctrl_pkt_cnt), 64'hffff);
        clear_log();
        send_ctrl(1, 64'hc400_0000_0000_0000);
        cyc();
        check("mrst_next_pkt", log_dat[0], 64'hc400_0000_0000_0000);
        check("mrst_ctrl_cnt", 64'(ctrl_pkt_cnt), 64'd1);
        check("wrap_ctrl_cnt", 64'(w_ctrl_pkt_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udt_tx_scheduler.md
# udt_tx_scheduler

Packet-atomic arbiter sharing the single UDP transmit stream between the UDT control-packet source (handshake/ACK/NAK/keep-alive/shutdown) and the UDT data-packet source. Control traffic has priority; an optional anti-starvation counter guarantees data progress. Sits between the UDT protocol engines and the UDP/IP stack. Drives the `udp_tx_*` stream and its address/port sidecar, latched per packet from the configuration registers.

## Interface
Parameters:
- `FPGA_MAC_SRC`, 48'hba0203040506, source MAC driven on `udp_tx_mac_src`
- `FPGA_MAC_DES`, 48'hffffffffffff, reset value of `udp_tx_mac_dest`
- `FPGA_IP_SRC`, 32'hc0a8006f, source IP driven on `udp_tx_ip_src`
- `FPGA_IP_DES_DEAFAULT`, 32'hc0a800ff, reset value of `udp_tx_ip_dest`
- `PORT`, 10086, local port; low 16 bits drive `udp_tx_port_src` and reset `udp_tx_port_dest`
- `CTRL_BURST_MAX`, 4, max consecutive control packets while data waits (1..255; used only with `UDT_TX_FAIR_EN`)

Ports:
- `core_clk` in 1: single clock
- `core_rst` in 1: synchronous, active-high reset
- `cfg_mac_dest` in 48 / `cfg_ip_dest` in 32 / `cfg_port_dest` in 16: peer address from configuration, sampled at grant
- `ctrl_tvalid` in 1, `ctrl_tready` out 1, `ctrl_tdata` in 64, `ctrl_tkeep` in 8, `ctrl_tlast` in 1: control packet stream
- `data_tvalid` in 1, `data_tready` out 1, `data_tdata` in 64, `data_tkeep` in 8, `data_tlast` in 1: data packet stream
- `udp_tx_tready` in 1, `udp_tx_tvalid` out 1, `udp_tx_tlast` out 1, `udp_tx_tkeep` out 8, `udp_tx_tdata` out 64: granted stream to UDP
- `udp_tx_mac_src` out 48, `udp_tx_mac_dest` out 48, `udp_tx_ip_src` out 32, `udp_tx_ip_dest` out 32, `udp_tx_port_src` out 16, `udp_tx_port_dest` out 16: per-packet sidecar
- `sched_busy` out 1: high while a packet is granted
- `ctrl_pkt_cnt` out 16 / `data_pkt_cnt` out 16: packets completed per source

## Operation
- State machine: IDLE, CTRL, DATA.
- IDLE:
  - Sample `ctrl_tvalid` and `data_tvalid`.
  - Selection: control wins, except under the fairness rule (Configuration); data is granted if it is the only requester.
  - On grant: latch `cfg_*` into `udp_tx_*_dest`, then go to CTRL or DATA.
  - No requester: stay in IDLE.
- CTRL / DATA:
  - Combinational pass-through of the granted source: tvalid, tdata, tkeep and tlast are forwarded to `udp_tx_*`.
  - `udp_tx_tready` is routed back to the granted source's tready.
  - The non-granted tready is 0.
  - When not granted, outputs are forced to 0.
- End of packet: a beat with tvalid & tready & tlast returns the FSM to IDLE and increments that source's counter.
- Grant is never revoked mid-packet. Changes on `cfg_*` during a packet do not affect the sidecar until the next grant.
- Counters are 16-bit and wrap 16'hFFFF -> 0.
- `sched_busy` = (state != IDLE).
- Reset values:
  - All tready/tvalid/tlast/tkeep/tdata outputs are 0; counters are 0; state is IDLE.
  - `udp_tx_mac_dest` = `FPGA_MAC_DES`, `udp_tx_ip_dest` = `FPGA_IP_DES_DEAFAULT`, `udp_tx_port_dest` = `PORT[15:0]`.
  - Source fields are constant parameters.
- Reset mid-packet: the packet is abandoned immediately and tready drops the same cycle reset is sampled. Upstream and UDP-side flushing are their own responsibility.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at cycle N gives `udp_tx_tvalid` at N+1.
- Datapath latency in the granted state: 0 cycles (combinational). Throughput is 1 beat/cycle while `udp_tx_tready` is high.
- Inter-packet gap: exactly 1 idle cycle after each tlast handshake.
- Both sources valid in the same IDLE cycle: resolved by the priority/fairness rule only. No tie cycles.
- `udp_tx_tready` low: granted source sees tready low and holds its beat. AXI-stream rule: tvalid must not drop once asserted.
- Single-beat packet (tlast on first beat): legal; FSM occupies CTRL/DATA for exactly one handshake cycle.

## Configuration
- `UDT_TX_FAIR_EN` defined:
  - An 8-bit counter `ctrl_run` increments on each control grant while data is not granted, saturating at 255; it clears on each data grant.
  - In IDLE, if `ctrl_run >= CTRL_BURST_MAX` and `data_tvalid`, data is granted even with `ctrl_tvalid` high.
  - `ctrl_run` resets to 0.
- `UDT_TX_FAIR_EN` undefined: strict control priority and no counter. Data can starve indefinitely.

## Test plan
- Reset then idle: after `core_rst` pulse, all stream outputs are 0, `udp_tx_ip_dest` = 32'hc0a800ff, and `udp_tx_port_dest` = 16'd10086.
- Single data packet: 3 beats, `cfg_ip_dest` = 32'hc0a80010, tready always 1. Output beats appear 1 cycle later with matching tdata/tkeep, `udp_tx_ip_dest` = 32'hc0a80010, and `data_pkt_cnt` = 1.
- Simultaneous request: both valid in the same cycle. Control packet is output first, then 1 idle cycle, then the data packet; no interleaving of beats.
- Backpressure mid-packet: `udp_tx_tready` low for 5 cycles on beat 2 of 4. Beat 2 is held stable, the source sees tready 0, the packet completes intact, and `cfg_*` changed during the stall is not reflected until the next packet.
- Fairness, with `UDT_TX_FAIR_EN` and `CTRL_BURST_MAX` = 4: continuous control plus pending data gives the order C,C,C,C,D,C,C,C,C,D. Without the macro: all C, and `data_pkt_cnt` stays 0.
- Reset mid-packet and counter wrap:
  - Reset asserted on beat 2: tready drops that cycle, and the next packet starts cleanly from IDLE.
  - Preload 65535 packets: `ctrl_pkt_cnt` wraps to 0.
